// File: rtl/seg_display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler_if
// Description : Digit load handshake and seven-segment pad bundle for
//               seg_display_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_scheduler_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_suppress;
    logic                    load_req;
    logic                    load_ack;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;

    modport master (
        output enable, digits_in, dp_in, lz_suppress, load_req,
        input  load_ack, seg_out, dp_out, digit_sel, frame_done
    );

    modport slave (
        input  enable, digits_in, dp_in, lz_suppress, load_req,
        output load_ack, seg_out, dp_out, digit_sel, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler
// Description : Multiplexed seven-segment scanner with blanking gap,
//               leading-zero suppression and frame-aligned digit loading.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter logic [15:0] DWELL_CYCLES = 16'd1000,
    parameter logic [7:0]  BLANK_CYCLES = 8'd10
) (
    input  logic                    clk,
    input  logic                    rst,
    seg_display_scheduler_if.slave  bus
);

    localparam int unsigned         C_IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [C_IDX_W-1:0]  C_LAST_IDX  = C_IDX_W'(NUM_DIGITS - 1);
    localparam logic [15:0]         C_DWELL_END = DWELL_CYCLES - 16'd1;
    localparam logic [15:0]         C_BLANK_END = {8'd0, BLANK_CYCLES} - 16'd1;
    localparam bit                  C_NO_BLANK  = (BLANK_CYCLES == 8'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [C_IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    w_frame_end;
    logic                    w_capture;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;

        w_frame_end = (state_q == ST_SHOW) && (idx_q == C_LAST_IDX) && (cnt_q == C_DWELL_END);
        // The ack guard stops a requester that is still high during its ack cycle from loading twice
        w_capture   = bus.load_req && (((state_q == ST_IDLE) && !load_ack_q) || w_frame_end);

        if (w_capture) begin
            shadow_dig_d = bus.digits_in;
            shadow_dp_d  = bus.dp_in;
            load_ack_d   = 1'b1;
        end

        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = C_NO_BLANK ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == C_BLANK_END) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == C_DWELL_END) begin
                        cnt_d   = '0;
                        state_d = C_NO_BLANK ? ST_SHOW : ST_BLANK;
                        if (idx_q == C_LAST_IDX) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + C_IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from next-state so the pads register alongside the FSM
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run   = w_zero_run && (shadow_dig_d[4*k +: 4] == 4'd0);
            w_lz_mask[k] = w_zero_run;
        end
        w_digit = shadow_dig_d[4*int'(idx_d) +: 4];

        sel_d = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_d == ST_SHOW) begin
            sel_d[idx_d] = 1'b1;
            dp_d         = shadow_dp_d[idx_d];
            if (bus.lz_suppress && (idx_d != '0) && w_lz_mask[idx_d]) begin
                seg_d = 7'd0;
            end else begin
                seg_d = seg_decode(w_digit);
            end
        end
    end

    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;
    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.digit_sel  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scheduler
// Description : Self-checking bench; expected pad values come from a
//               time-position model of the scan frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

    localparam int N  = 4;
    localparam int DI = 4;
    localparam int BA = 2;
    localparam int BB = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_display_scheduler_if #(.NUM_DIGITS(N)) ifa ();
    seg_display_scheduler_if #(.NUM_DIGITS(N)) ifb ();

    seg_display_scheduler #(.NUM_DIGITS(N), .DWELL_CYCLES(16'd4), .BLANK_CYCLES(8'd2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seg_display_scheduler #(.NUM_DIGITS(N), .DWELL_CYCLES(16'd4), .BLANK_CYCLES(8'd0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [13:0] act_a, act_b;
    assign act_a = {ifa.digit_sel, ifa.seg_out, ifa.dp_out, ifa.frame_done, ifa.load_ack};
    assign act_b = {ifb.digit_sel, ifb.seg_out, ifb.dp_out, ifb.frame_done, ifb.load_ack};

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] sh_dig;
    logic [3:0]  sh_dp;
    logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // t counts cycles since the edge that left IDLE (t=0 is the first scanning cycle)
    function automatic logic [13:0] exp_vec(input int t, input int b, input logic [15:0] dg,
                                            input logic [3:0] dpm, input logic lz, input logic ack);
        int per, p, d, w, h;
        logic [3:0] sel;
        logic [6:0] seg;
        logic dpo, fd;
        per = N * (b + DI);
        p   = t % per;
        d   = p / (b + DI);
        w   = p % (b + DI);
        sel = '0; seg = '0; dpo = 1'b0;
        fd  = (t > 0) && (t % per == 0);
        h   = -1;
        for (int k = 0; k < N; k++) if (dg[4*k +: 4] != 4'd0) h = k;
        if (w >= b) begin
            sel = 4'(1 << d);
            dpo = dpm[d];
            seg = (lz && d != 0 && d > h) ? 7'd0 : seg_tbl[dg[4*d +: 4]];
        end
        return {sel, seg, dpo, fd, ack};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: loads dut_a while IDLE and reports the ack seen on the two following cycles
    task automatic idle_load(input logic [15:0] dg, input logic [3:0] dp,
                             output logic ack1, output logic ack2);
        ifa.digits_in = dg;
        ifa.dp_in     = dp;
        ifa.load_req  = 1'b1;
        tick();
        ack1 = ifa.load_ack;
        ifa.load_req  = 1'b0;
        ifa.digits_in = 16'($urandom);
        ifa.dp_in     = 4'($urandom);
        tick();
        ack2   = ifa.load_ack;
        sh_dig = dg;
        sh_dp  = dp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.enable = 1'b1; ifa.load_req = 1'b1; ifa.lz_suppress = 1'b0;
        ifa.digits_in = 16'($urandom); ifa.dp_in = 4'($urandom);
        ifb.enable = 1'b1; ifb.load_req = 1'b1; ifb.lz_suppress = 1'b0;
        ifb.digits_in = 16'($urandom); ifb.dp_in = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp += 2;
            if (act_a !== 14'd0) begin n_fail++; $display("FAIL reset_a cyc=%0d actual=%h expected=0000", i, act_a); end
            if (act_b !== 14'd0) begin n_fail++; $display("FAIL reset_b cyc=%0d actual=%h expected=0000", i, act_b); end
        end
        rst = 1'b0;
        ifa.enable = 1'b0; ifa.load_req = 1'b0;
        ifb.enable = 1'b0; ifb.load_req = 1'b0;
        tick();
        n_cmp++;
        if (act_a !== 14'd0) begin n_fail++; $display("FAIL idle_after_reset actual=%h expected=0000", act_a); end
        sh_dig = '0;
        sh_dp  = '0;
    endtask

    task automatic test_scan_timing();
        logic [13:0] e;
        ifa.lz_suppress = 1'b0;
        ifa.enable = 1'b1;
        for (int t = 0; t < 48; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL scan_timing t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        tick();
        n_cmp++;
        if (act_a !== 14'd0) begin n_fail++; $display("FAIL scan_to_idle actual=%h expected=0000", act_a); end
    endtask

    task automatic test_decode();
        logic a1, a2;
        logic [13:0] e;
        idle_load(16'h70A3, 4'b0101, a1, a2);
        n_cmp++;
        if ({a1, a2} !== 2'b10) begin n_fail++; $display("FAIL decode_ack actual=%b expected=10", {a1, a2}); end
        ifa.lz_suppress = 1'b0;
        ifa.enable = 1'b1;
        for (int t = 0; t < 24; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL decode t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        tick();
    endtask

    task automatic test_lz();
        logic a1, a2, lz;
        logic [15:0] dg;
        logic [13:0] e;
        for (int it = 0; it < 8; it++) begin
            if (it == 0)      begin dg = 16'h0005; lz = 1'b1; end
            else if (it == 1) begin dg = 16'h0000; lz = 1'b1; end
            else begin
                for (int k = 0; k < N; k++)
                    dg[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                lz = 1'($urandom_range(0, 3) != 0);
            end
            idle_load(dg, 4'($urandom), a1, a2);
            n_cmp++;
            if ({a1, a2} !== 2'b10) begin n_fail++; $display("FAIL lz_ack it=%0d actual=%b expected=10", it, {a1, a2}); end
            ifa.lz_suppress = lz;
            ifa.enable = 1'b1;
            for (int t = 0; t < 24; t++) begin
                tick();
                e = exp_vec(t, BA, sh_dig, sh_dp, lz, 1'b0);
                n_cmp++;
                if (act_a !== e) begin n_fail++; $display("FAIL lz it=%0d dg=%h t=%0d actual=%h expected=%h", it, dg, t, act_a, e); end
            end
            ifa.enable = 1'b0;
            tick();
        end
        ifa.lz_suppress = 1'b0;
    endtask

    task automatic test_midframe_load();
        logic [15:0] pend_dig;
        logic [3:0]  pend_dp;
        logic [13:0] e;
        pend_dig = '0;
        pend_dp  = '0;
        ifa.enable = 1'b1;
        for (int t = 0; t < 48; t++) begin
            tick();
            if (t == 24) begin sh_dig = pend_dig; sh_dp = pend_dp; end
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, t == 24);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL midframe t=%0d actual=%h expected=%h", t, act_a, e); end
            if (t == 9 || t == 15) begin
                pend_dig = 16'($urandom);
                pend_dp  = 4'($urandom);
                ifa.digits_in = pend_dig;
                ifa.dp_in     = pend_dp;
                ifa.load_req  = 1'b1;
            end
            if (t == 24) begin
                ifa.load_req  = 1'b0;
                ifa.digits_in = 16'($urandom);
            end
        end
        ifa.enable = 1'b0;
        tick();
    endtask

    task automatic test_enable_at_frame_end();
        logic [15:0] nv;
        logic [3:0]  nd;
        logic [13:0] e;
        nv = 16'($urandom);
        nd = 4'($urandom);
        ifa.enable = 1'b1;
        for (int t = 0; t < 24; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL fe_scan t=%0d actual=%h expected=%h", t, act_a, e); end
            if (t == 10) begin ifa.digits_in = nv; ifa.dp_in = nd; ifa.load_req = 1'b1; end
        end
        ifa.enable = 1'b0;
        tick();
        n_cmp++;
        if (act_a !== 14'b0000_0000000_0_0_1) begin n_fail++; $display("FAIL fe_drop actual=%h expected=0001", act_a); end
        ifa.load_req = 1'b0;
        sh_dig = nv;
        sh_dp  = nd;
        tick();
        n_cmp++;
        if (act_a !== 14'd0) begin n_fail++; $display("FAIL fe_idle actual=%h expected=0000", act_a); end
        ifa.enable = 1'b1;
        for (int t = 0; t < 24; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL fe_new t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        tick();
    endtask

    task automatic test_enable_drop();
        logic [13:0] e;
        ifa.enable = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL drop_pre t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (act_a !== 14'd0) begin n_fail++; $display("FAIL drop_idle cyc=%0d actual=%h expected=0000", i, act_a); end
        end
        ifa.enable = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL drop_restart t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        tick();
        ifb.enable = 1'b1;
        for (int t = 0; t < 32; t++) begin
            tick();
            e = exp_vec(t, BB, 16'd0, 4'd0, 1'b0, 1'b0);
            n_cmp += 2;
            if (act_b !== e) begin n_fail++; $display("FAIL noblank t=%0d actual=%h expected=%h", t, act_b, e); end
            if (ifb.digit_sel === 4'd0) begin n_fail++; $display("FAIL noblank_gap t=%0d actual=%b expected=nonzero", t, ifb.digit_sel); end
        end
        ifb.enable = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic a1, a2;
        logic [13:0] e;
        idle_load(16'h9C41, 4'b1011, a1, a2);
        n_cmp++;
        if ({a1, a2} !== 2'b10) begin n_fail++; $display("FAIL rmid_ack actual=%b expected=10", {a1, a2}); end
        ifa.lz_suppress = 1'b0;
        ifa.enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL rmid_pre t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        rst = 1'b1;
        ifa.load_req  = 1'b1;
        ifa.digits_in = 16'($urandom);
        tick();
        n_cmp++;
        if (act_a !== 14'd0) begin n_fail++; $display("FAIL rmid_reset actual=%h expected=0000", act_a); end
        rst = 1'b0;
        ifa.load_req = 1'b0;
        sh_dig = '0;
        sh_dp  = '0;
        for (int t = 0; t < 24; t++) begin
            tick();
            e = exp_vec(t, BA, sh_dig, sh_dp, 1'b0, 1'b0);
            n_cmp++;
            if (act_a !== e) begin n_fail++; $display("FAIL rmid_post t=%0d actual=%h expected=%h", t, act_a, e); end
        end
        ifa.enable = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_timing();
        test_decode();
        test_lz();
        test_midframe_load();
        test_enable_at_frame_end();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
